// File: rtl/led_pkg.sv
// Shared constants for the LED scan display: active-low segment codes (a..g) and anode idle value.
package led_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/LEDdecoder.sv
// Hex nibble to active-low 7-segment code (purely combinational).
module LEDdecoder
    import led_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] led_c
);

    always_comb begin
        led_c = SEG_BLANK;
        unique case (hex)
            4'h0: led_c = SEG_0;
            4'h1: led_c = SEG_1;
            4'h2: led_c = SEG_2;
            4'h3: led_c = SEG_3;
            4'h4: led_c = SEG_4;
            4'h5: led_c = SEG_5;
            4'h6: led_c = SEG_6;
            4'h7: led_c = SEG_7;
            4'h8: led_c = SEG_8;
            4'h9: led_c = SEG_9;
            4'hA: led_c = SEG_A;
            4'hB: led_c = SEG_B;
            4'hC: led_c = SEG_C;
            4'hD: led_c = SEG_D;
            4'hE: led_c = SEG_E;
            default: led_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with shadowed display data and per-slot dead time.
// Optional leading-zero blanking when LED_SCAN_LZ_BLANK_EN is defined.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 20000,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digit_data,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      shadow, active, active_nxt;
    logic             slot_end, commit;
    logic [3:0]       nib_nxt;
    logic [6:0]       seg_dec_c, seg_nxt;
    logic [3:0]       an_nxt;
    logic             blank_nxt;
    logic             frame_done_nxt;

    LEDdecoder u_dec (
        .hex   (nib_nxt),
        .led_c (seg_dec_c)
    );

    // Outputs are computed from next-cycle state so an/seg come straight from flops.
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        commit     = slot_end && (idx == 2'd0);
        cnt_nxt    = slot_end ? '0 : cnt + CNT_W'(1);
        idx_nxt    = slot_end ? idx - 2'd1 : idx;
        active_nxt = commit ? shadow : active;
        nib_nxt    = 4'(active_nxt >> {idx_nxt, 2'b00});

`ifdef LED_SCAN_LZ_BLANK_EN
        unique case (idx_nxt)
            2'd3:    blank_nxt = (active_nxt[15:12] == 4'h0);
            2'd2:    blank_nxt = (active_nxt[15:8] == 8'h00);
            2'd1:    blank_nxt = (active_nxt[15:4] == 12'h000);
            default: blank_nxt = 1'b0;
        endcase
`else
        blank_nxt = 1'b0;
`endif

        seg_nxt = blank_nxt ? SEG_BLANK : seg_dec_c;
        an_nxt  = AN_OFF;
        if (!blank_nxt && (cnt_nxt >= CNT_DEAD)) begin
            an_nxt[idx_nxt] = 1'b0;
        end
        frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd3;
            shadow     <= '0;
            active     <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            active     <= active_nxt;
            if (load) begin
                shadow <= digit_data;
            end
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with CLK_DIV=16, DEAD_CYCLES=4 (64-cycle frames).
`timescale 1ns/1ps
module tb_led_scan_ctrl;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned DEAD    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digit_data;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    led_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digit_data (digit_data),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int p; logic [3:0] an; logic [6:0] seg; } vec_t;
    typedef struct { int p; logic [15:0] data; } ld_t;

    vec_t       vecs[$];
    ld_t        loads[$];
    logic [6:0] segtab [16];
    int         checks   = 0;
    int         failures = 0;
    int         p        = 0;
    int         phase    = 0;
    int         lowcnt [4];

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s p=%0d phase=%0d actual=%b required=%b", name, p, phase, act, exp);
        end
    endtask

    // Expected samples for one frame: end of dead time, first lit cycle, last cycle of each slot.
    task automatic add_frame(input int f, input logic [15:0] value);
        logic       lz;
        logic [3:0] nib;
        logic       blank;
        int         s;
        logic [3:0] an_on;
        logic [6:0] sg;
        lz = 1'b1;
        for (int d = 3; d >= 0; d--) begin
            nib   = value[d*4 +: 4];
            lz    = lz & (nib == 4'h0);
            blank = 1'b0;
`ifdef LED_SCAN_LZ_BLANK_EN
            blank = lz & (d != 0);
`endif
            s     = f + 16 * (3 - d);
            an_on = 4'hF;
            an_on[d] = 1'b0;
            sg    = blank ? 7'h7F : segtab[nib];
            vecs.push_back('{s + 3,  4'hF, sg});
            vecs.push_back('{s + 4,  blank ? 4'hF : an_on, sg});
            vecs.push_back('{s + 15, blank ? 4'hF : an_on, sg});
        end
    endtask

    // Sample at negedge for position p, drive inputs for that cycle, then advance one clock.
    task automatic run_to(input int last);
        while (1) begin
            foreach (vecs[i]) begin
                if (vecs[i].p == p) begin
                    check($sformatf("an@%0d", p), 11'(an), 11'(vecs[i].an));
                    check($sformatf("seg@%0d", p), 11'(seg), 11'(vecs[i].seg));
                end
            end
            check("frame_done", 11'(frame_done), 11'((p % 64) == 63));
            check("an_onehot", 11'($countones(~an) <= 1), 11'(1));
            if (phase == 1 && p >= 64 && p < 128) begin
                for (int d = 0; d < 4; d++) lowcnt[d] += int'(!an[d]);
                if (p == 127) begin
                    for (int d = 0; d < 4; d++)
                        check($sformatf("an%0d_low_cycles", d), 11'(lowcnt[d]), 11'(12));
                end
            end
            load = 1'b0;
            foreach (loads[i]) begin
                if (loads[i].p == p) begin
                    load       = 1'b1;
                    digit_data = loads[i].data;
                end
            end
            if (p == last) return;
            @(posedge clk);
            p++;
            @(negedge clk);
        end
    endtask

    initial begin
        segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int d = 0; d < 4; d++) lowcnt[d] = 0;
        reset      = 1'b1;
        load       = 1'b0;
        digit_data = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 11'(an), 11'(4'hF));
        check("rst_seg", 11'(seg), 11'(7'h7F));
        check("rst_frame_done", 11'(frame_done), 11'(0));

        // Frame-aligned loads: mid-frame, double load, load on the commit cycle, pending at reset.
        phase = 1;
        loads.push_back('{2,   16'h1234});
        loads.push_back('{70,  16'hAAAA});
        loads.push_back('{100, 16'hF00D});
        loads.push_back('{191, 16'h5678});
        loads.push_back('{260, 16'h0070});
        loads.push_back('{390, 16'h9999});
        add_frame(0,   16'h0000);
        add_frame(64,  16'h1234);
        add_frame(128, 16'hF00D);
        add_frame(192, 16'hF00D);
        add_frame(256, 16'h5678);
        add_frame(320, 16'h0070);

        reset = 1'b0;
        p     = 0;
        check("release_an", 11'(an), 11'(4'hF));
        run_to(407);

        // Digit 2, cnt=7: anode lit, then asynchronous reset mid-cycle.
        check("pre_rst_an", 11'(an), 11'(4'b1011));
        #2 reset = 1'b1;
        #1;
        check("async_rst_an", 11'(an), 11'(4'hF));
        check("async_rst_seg", 11'(seg), 11'(7'h7F));
        check("async_rst_fd", 11'(frame_done), 11'(0));
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Restart: digit 3 from cnt=0, pending 9999 must be gone.
        phase = 2;
        vecs.delete();
        loads.delete();
        add_frame(0,  16'h0000);
        add_frame(64, 16'h0000);
        reset = 1'b0;
        p     = 0;
        check("restart_an", 11'(an), 11'(4'hF));
        run_to(127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
